// File: rtl/axi32_pkg.sv
// Shared definitions for the axi32 access arbiter: FSM encoding, AXI response
// codes and the default slave timeout.
package axi32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;
  localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/axi32_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module axi32_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/axi32_access_arbiter.sv
// Shares one AXI4-Lite master port between two requesters, one transaction in
// flight at a time, with a per-transaction slave timeout.
module axi32_access_arbiter
  import axi32_pkg::*;
#(
  parameter int         datawidth      = 32,
  parameter int         addrwidth      = 8,
  parameter logic [7:0] timeout_cycles = TIMEOUT_DEFAULT
) (
  input  logic                       s_axi_clk_in,
  input  logic                       s_axi_reset_n_in,
  input  logic [1:0]                 req_valid_in,
  input  logic [1:0]                 req_write_in,
  input  logic [2*addrwidth-1:0]     req_addr_in,
  input  logic [2*datawidth-1:0]     req_wdata_in,
  input  logic [2*datawidth/8-1:0]   req_wstrb_in,
  output logic [1:0]                 req_accept_out,
  output logic [1:0]                 rsp_valid_out,
  output logic [datawidth-1:0]       rsp_rdata_out,
  output logic [1:0]                 rsp_resp_out,
  output logic                       rsp_timeout_out,
  output logic [addrwidth-1:0]       m_axi_awaddr_out,
  output logic                       m_axi_awvalid_out,
  input  logic                       m_axi_awready_in,
  output logic [datawidth-1:0]       m_axi_wdata_out,
  output logic [datawidth/8-1:0]     m_axi_wstrb_out,
  output logic                       m_axi_wvalid_out,
  input  logic                       m_axi_wready_in,
  input  logic [1:0]                 m_axi_bresp_in,
  input  logic                       m_axi_bvalid_in,
  output logic                       m_axi_bready_out,
  output logic [addrwidth-1:0]       m_axi_araddr_out,
  output logic                       m_axi_arvalid_out,
  input  logic                       m_axi_arready_in,
  input  logic [datawidth-1:0]       m_axi_rdata_in,
  input  logic [1:0]                 m_axi_rresp_in,
  input  logic                       m_axi_rvalid_in,
  output logic                       m_axi_rready_out
);

  localparam int strbwidth = datawidth / 8;

  state_t                 state;
  logic                   last_grant;
  logic                   gnt_idx;
  logic                   wr_lat;
  logic                   to_lat;
  logic [1:0]             resp_lat;
  logic [datawidth-1:0]   rdata_lat;
  logic [7:0]             tcnt;
  logic [7:0]             tcnt_nxt;
  logic [1:0]             grant;
  logic                   busy;
  logic                   timeout_hit;
  logic                   take;
  logic                   wr_sel;
  logic [addrwidth-1:0]   addr_lat;
  logic [datawidth-1:0]   wdata_lat;
  logic [strbwidth-1:0]   wstrb_lat;

  axi32_rr_arbiter2 u_arb (
    .req        (req_valid_in),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant)
  );

  assign busy        = (state != IDLE) && (state != DONE);
  assign tcnt_nxt    = tcnt + 8'd1;
  assign timeout_hit = busy && (tcnt_nxt == timeout_cycles);
  assign take        = (state == IDLE) && (|grant);
  assign wr_sel      = grant[1] ? req_write_in[1] : req_write_in[0];

  // Request payload is captured once at grant so requesters may change or drop
  // their inputs while the transaction is in flight.
  always_ff @(posedge s_axi_clk_in) begin
    if (take) begin
      if (grant[1]) begin
        addr_lat  <= req_addr_in[addrwidth +: addrwidth];
        wdata_lat <= req_wdata_in[datawidth +: datawidth];
        wstrb_lat <= req_wstrb_in[strbwidth +: strbwidth];
      end else begin
        addr_lat  <= req_addr_in[0 +: addrwidth];
        wdata_lat <= req_wdata_in[0 +: datawidth];
        wstrb_lat <= req_wstrb_in[0 +: strbwidth];
      end
    end
  end

  assign m_axi_awaddr_out = addr_lat;
  assign m_axi_araddr_out = addr_lat;
  assign m_axi_wdata_out  = wdata_lat;
  assign m_axi_wstrb_out  = wstrb_lat;

  always_ff @(posedge s_axi_clk_in or negedge s_axi_reset_n_in) begin
    if (!s_axi_reset_n_in) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      gnt_idx           <= 1'b0;
      wr_lat            <= 1'b0;
      to_lat            <= 1'b0;
      resp_lat          <= RESP_OKAY;
      rdata_lat         <= '0;
      tcnt              <= 8'd0;
      req_accept_out    <= 2'b00;
      rsp_valid_out     <= 2'b00;
      rsp_rdata_out     <= '0;
      rsp_resp_out      <= RESP_OKAY;
      rsp_timeout_out   <= 1'b0;
      m_axi_awvalid_out <= 1'b0;
      m_axi_wvalid_out  <= 1'b0;
      m_axi_bready_out  <= 1'b0;
      m_axi_arvalid_out <= 1'b0;
      m_axi_rready_out  <= 1'b0;
    end else begin
      req_accept_out  <= 2'b00;
      rsp_valid_out   <= 2'b00;
      rsp_timeout_out <= 1'b0;
      if (busy) tcnt <= tcnt_nxt;

      if (timeout_hit) begin
        m_axi_awvalid_out <= 1'b0;
        m_axi_wvalid_out  <= 1'b0;
        m_axi_bready_out  <= 1'b0;
        m_axi_arvalid_out <= 1'b0;
        m_axi_rready_out  <= 1'b0;
        resp_lat          <= RESP_SLVERR;
        rdata_lat         <= '0;
        to_lat            <= 1'b1;
        state             <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (take) begin
              gnt_idx        <= grant[1];
              wr_lat         <= wr_sel;
              to_lat         <= 1'b0;
              tcnt           <= 8'd0;
              req_accept_out <= grant;
              // Response-side ready goes up with the request so the slave
              // always sees it high at the address/data handshake.
              if (wr_sel) begin
                m_axi_awvalid_out <= 1'b1;
                m_axi_wvalid_out  <= 1'b1;
                m_axi_bready_out  <= 1'b1;
                state             <= WR_ADDR_DATA;
              end else begin
                m_axi_arvalid_out <= 1'b1;
                m_axi_rready_out  <= 1'b1;
                state             <= RD_ADDR;
              end
            end
          end
          WR_ADDR_DATA: begin
            if (m_axi_awready_in) m_axi_awvalid_out <= 1'b0;
            if (m_axi_wready_in)  m_axi_wvalid_out  <= 1'b0;
            if ((!m_axi_awvalid_out || m_axi_awready_in) &&
                (!m_axi_wvalid_out  || m_axi_wready_in))
              state <= WR_RESP;
          end
          WR_RESP: begin
            if (m_axi_bvalid_in) begin
              resp_lat         <= m_axi_bresp_in;
              m_axi_bready_out <= 1'b0;
              state            <= DONE;
            end
          end
          RD_ADDR: begin
            if (m_axi_arready_in) begin
              m_axi_arvalid_out <= 1'b0;
              state             <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (m_axi_rvalid_in) begin
              resp_lat         <= m_axi_rresp_in;
              rdata_lat        <= m_axi_rdata_in;
              m_axi_rready_out <= 1'b0;
              state            <= DONE;
            end
          end
          DONE: begin
            rsp_valid_out[gnt_idx] <= 1'b1;
            rsp_resp_out           <= resp_lat;
            rsp_timeout_out        <= to_lat;
            // Write completions keep the last read data visible.
            if (!wr_lat || to_lat) rsp_rdata_out <= rdata_lat;
            last_grant             <= gnt_idx;
            state                  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi32_access_arbiter.sv
// Directed bench for axi32_access_arbiter against a small AXI4-Lite register
// cell model (ID at 0x00, RW at 0x04/0x08, decode error elsewhere).
module tb_axi32_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid_in, req_write_in;
  logic [15:0] req_addr_in;
  logic [63:0] req_wdata_in;
  logic [7:0]  req_wstrb_in;
  logic [1:0]  req_accept_out, rsp_valid_out, rsp_resp_out;
  logic [31:0] rsp_rdata_out;
  logic        rsp_timeout_out;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  logic        stall_ar, stall_b;
  logic [31:0] reg04, reg08;
  logic        aw_seen, w_seen;

  int errors = 0;
  int checks = 0;

  logic [1:0]  acc_q[$];
  logic [1:0]  who_q[$];
  logic [1:0]  resp_q[$];
  logic [31:0] rd_q[$];
  logic        to_q[$];
  int          lat_q[$];
  int          arv_cycles;

  typedef struct {
    int          who;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  axi32_access_arbiter #(
    .datawidth(32), .addrwidth(8), .timeout_cycles(8'd16)
  ) dut (
    .s_axi_clk_in      (clk),
    .s_axi_reset_n_in  (rst_n),
    .req_valid_in      (req_valid_in),
    .req_write_in      (req_write_in),
    .req_addr_in       (req_addr_in),
    .req_wdata_in      (req_wdata_in),
    .req_wstrb_in      (req_wstrb_in),
    .req_accept_out    (req_accept_out),
    .rsp_valid_out     (rsp_valid_out),
    .rsp_rdata_out     (rsp_rdata_out),
    .rsp_resp_out      (rsp_resp_out),
    .rsp_timeout_out   (rsp_timeout_out),
    .m_axi_awaddr_out  (awaddr),
    .m_axi_awvalid_out (awvalid),
    .m_axi_awready_in  (awready),
    .m_axi_wdata_out   (wdata),
    .m_axi_wstrb_out   (wstrb),
    .m_axi_wvalid_out  (wvalid),
    .m_axi_wready_in   (wready),
    .m_axi_bresp_in    (bresp),
    .m_axi_bvalid_in   (bvalid),
    .m_axi_bready_out  (bready),
    .m_axi_araddr_out  (araddr),
    .m_axi_arvalid_out (arvalid),
    .m_axi_arready_in  (arready),
    .m_axi_rdata_in    (rdata),
    .m_axi_rresp_in    (rresp),
    .m_axi_rvalid_in   (rvalid),
    .m_axi_rready_out  (rready)
  );

  // Register cell: zero-wait address/data ready, response one cycle later.
  assign awready = 1'b1;
  assign wready  = 1'b1;
  assign arready = !stall_ar;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
      reg04 <= 32'h0; reg08 <= 32'h0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (((awvalid && awready) || aw_seen) && ((wvalid && wready) || w_seen)) begin
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
        case (awaddr)
          8'h00:   bresp <= 2'b00;
          8'h04:   begin reg04 <= merge(reg04, wdata, wstrb); bresp <= 2'b00; end
          8'h08:   begin reg08 <= merge(reg08, wdata, wstrb); bresp <= 2'b00; end
          default: bresp <= 2'b11;
        endcase
        if (!stall_b) bvalid <= 1'b1;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready)   w_seen  <= 1'b1;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        case (araddr)
          8'h00:   begin rdata <= 32'h54460000; rresp <= 2'b00; end
          8'h04:   begin rdata <= reg04;        rresp <= 2'b00; end
          8'h08:   begin rdata <= reg08;        rresp <= 2'b00; end
          default: begin rdata <= 32'h0;        rresp <= 2'b11; end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present requests, then log accepts and responses until n_rsp responses
  // arrive. Without hold, an accepted requester drops and scrambles its inputs.
  task automatic issue(input logic [1:0] vld, input logic [1:0] wr,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input int n_rsp, input bit hold);
    int guard;
    int n;
    acc_q.delete(); who_q.delete(); resp_q.delete(); rd_q.delete();
    to_q.delete(); lat_q.delete();
    arv_cycles = 0;
    @(negedge clk);
    req_valid_in = vld;
    req_write_in = wr;
    req_addr_in  = {a1, a0};
    req_wdata_in = {d1, d0};
    req_wstrb_in = {s1, s0};
    guard = 0;
    n = 0;
    while (n < n_rsp && guard < 100) begin
      @(negedge clk);
      guard++;
      if (arvalid) arv_cycles++;
      if (|req_accept_out) begin
        acc_q.push_back(req_accept_out);
        if (!hold) begin
          for (int k = 0; k < 2; k++) begin
            if (req_accept_out[k]) begin
              req_valid_in[k]          = 1'b0;
              req_write_in[k]          = ~req_write_in[k];
              req_addr_in[k*8 +: 8]    = 8'hFF;
              req_wdata_in[k*32 +: 32] = 32'hDEADBEEF;
            end
          end
        end
      end
      if (|rsp_valid_out) begin
        who_q.push_back(rsp_valid_out);
        resp_q.push_back(rsp_resp_out);
        rd_q.push_back(rsp_rdata_out);
        to_q.push_back(rsp_timeout_out);
        lat_q.push_back(guard);
        n++;
      end
    end
    req_valid_in = 2'b00;
    check("response_count", 64'(n), 64'(n_rsp));
  endtask

  task automatic check_single(input string tag, input logic [1:0] who,
                              input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                              input logic exp_to, input int exp_lat);
    if (who_q.size() > 0 && acc_q.size() > 0) begin
      check({tag, "_accept"},  64'(acc_q[0]),  64'(who));
      check({tag, "_rsp_who"}, 64'(who_q[0]),  64'(who));
      check({tag, "_resp"},    64'(resp_q[0]), 64'(exp_resp));
      check({tag, "_rdata"},   64'(rd_q[0]),   64'(exp_rdata));
      check({tag, "_timeout"}, 64'(to_q[0]),   64'(exp_to));
      check({tag, "_latency"}, 64'(lat_q[0]),  64'(exp_lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    int guard;
    int pulses;
    logic [1:0] exp_who;

    vecs[0] = '{0, 1'b1, 8'h04, 32'h0000A5A5, 4'hF, 2'b00, 32'h54460000};
    vecs[1] = '{0, 1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h0000A5A5};
    vecs[2] = '{1, 1'b1, 8'h08, 32'h12345678, 4'h3, 2'b00, 32'h0000A5A5};
    vecs[3] = '{1, 1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h00005678};
    vecs[4] = '{1, 1'b0, 8'h0C, 32'h0,        4'h0, 2'b11, 32'h00000000};
    vecs[5] = '{0, 1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h54460000};
    vecs[6] = '{0, 1'b1, 8'h0C, 32'hDEADBEEF, 4'hF, 2'b11, 32'h54460000};

    req_valid_in = 2'b00; req_write_in = 2'b00; req_addr_in = 16'h0;
    req_wdata_in = 64'h0; req_wstrb_in = 8'h0;
    stall_ar = 1'b0; stall_b = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_accept",    64'(req_accept_out),  64'h0);
    check("reset_rsp_valid", 64'(rsp_valid_out),   64'h0);
    check("reset_resp",      64'(rsp_resp_out),    64'h0);
    check("reset_rdata",     64'(rsp_rdata_out),   64'h0);
    check("reset_timeout",   64'(rsp_timeout_out), 64'h0);
    check("reset_master_handshake", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First tie after reset: requester 0 first, then requester 1.
    issue(2'b11, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 2, 1'b0);
    if (acc_q.size() >= 2 && who_q.size() >= 2) begin
      check("tie_accept_first",  64'(acc_q[0]),  64'h1);
      check("tie_accept_second", 64'(acc_q[1]),  64'h2);
      check("tie_rsp_first",     64'(who_q[0]),  64'h1);
      check("tie_rsp_second",    64'(who_q[1]),  64'h2);
      check("tie_rdata_first",   64'(rd_q[0]),   64'h54460000);
      check("tie_rdata_second",  64'(rd_q[1]),   64'h54460000);
      check("tie_resp_second",   64'(resp_q[1]), 64'h0);
    end

    for (int i = 0; i < 7; i++) begin
      exp_who = (vecs[i].who == 0) ? 2'b01 : 2'b10;
      issue(exp_who, {vecs[i].wr, vecs[i].wr}, vecs[i].addr, vecs[i].addr,
            vecs[i].wdata, vecs[i].wdata, vecs[i].strb, vecs[i].strb, 1, 1'b0);
      check_single($sformatf("vec%0d", i), exp_who, vecs[i].exp_resp,
                   vecs[i].exp_rdata, 1'b0, 4);
    end

    // Slave never accepts the read address: give up after 16 busy cycles.
    stall_ar = 1'b1;
    issue(2'b01, 2'b00, 8'h04, 8'h04, 32'h0, 32'h0, 4'h0, 4'h0, 1, 1'b0);
    check_single("timeout", 2'b01, 2'b10, 32'h0, 1'b1, 18);
    check("timeout_arvalid_cycles", 64'(arv_cycles), 64'd16);
    check("timeout_master_idle", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'h0);
    stall_ar = 1'b0;

    issue(2'b01, 2'b00, 8'h04, 8'h04, 32'h0, 32'h0, 4'h0, 4'h0, 1, 1'b0);
    check_single("after_timeout", 2'b01, 2'b00, 32'h0000A5A5, 1'b0, 4);

    // Reset while waiting for a write response that never comes.
    stall_b = 1'b1;
    @(negedge clk);
    req_valid_in = 2'b10; req_write_in = 2'b10;
    req_addr_in = {8'h04, 8'h00}; req_wdata_in = {32'h11112222, 32'h0};
    req_wstrb_in = {4'hF, 4'h0};
    guard = 0;
    while (!(bready && !awvalid && !wvalid) && guard < 20) begin
      @(negedge clk);
      guard++;
      if (req_accept_out[1]) req_valid_in = 2'b00;
    end
    check("reset_test_reached_wr_resp", 64'(bready && !awvalid && !wvalid), 64'h1);
    req_valid_in = 2'b00;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({req_accept_out, rsp_valid_out, rsp_resp_out, rsp_timeout_out}), 64'h0);
    check("midreset_master",  64'({awvalid, wvalid, bready, arvalid, rready}), 64'h0);
    check("midreset_rdata",   64'(rsp_rdata_out), 64'h0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (|rsp_valid_out) pulses++;
    end
    rst_n = 1'b1;
    stall_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|rsp_valid_out) pulses++;
    end
    check("midreset_no_rsp_pulse", 64'(pulses), 64'h0);

    issue(2'b10, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 1, 1'b0);
    check_single("after_reset", 2'b10, 2'b00, 32'h54460000, 1'b0, 4);

    // Both requesters held for six transactions: strict alternation.
    issue(2'b11, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_who = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (acc_q.size() > i) check($sformatf("hold_accept%0d", i), 64'(acc_q[i]), 64'(exp_who));
      if (who_q.size() > i) check($sformatf("hold_rsp%0d", i), 64'(who_q[i]), 64'(exp_who));
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
